// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 sprite-draw engine.
// Holds the draw FSM state enum and the display geometry.
package chip8_pkg;

    localparam int FB_WIDTH  = 64;
    localparam int FB_HEIGHT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_READ,
        ST_WRITE,
        ST_SKIP,
        ST_DONE
    } sprite_state_t;

endpackage

// File: rtl/chip8_sprite_coord.sv
// Pixel coordinate generator for one sprite bit: px/py plus on-screen flag.
// CHIP8_SPRITE_WRAP_EN selects wrap-around instead of edge clipping.
module chip8_sprite_coord
    import chip8_pkg::*;
#(
    parameter int FB_W_BITS = 6,
    parameter int FB_H_BITS = 5
) (
    input  logic [FB_W_BITS-1:0] x0,
    input  logic [FB_H_BITS-1:0] y0,
    input  logic [2:0]           col,
    input  logic [3:0]           row,
    output logic [FB_W_BITS-1:0] px,
    output logic [FB_H_BITS-1:0] py,
    output logic                 on_screen
);

    logic [FB_W_BITS:0]   px_full;
    logic [FB_H_BITS+3:0] py_full;

    assign px_full = {1'b0, x0} + {{(FB_W_BITS-2){1'b0}}, col};
    assign py_full = {4'b0, y0} + {{FB_H_BITS{1'b0}}, row};
    assign px      = px_full[FB_W_BITS-1:0];
    assign py      = py_full[FB_H_BITS-1:0];

`ifdef CHIP8_SPRITE_WRAP_EN
    logic unused_wrap;
    assign unused_wrap = ^{px_full[FB_W_BITS], py_full[FB_H_BITS+3:FB_H_BITS]};
    assign on_screen   = 1'b1;
`else
    assign on_screen = (int'(px_full) < FB_WIDTH) && (int'(py_full) < FB_HEIGHT);
`endif

endmodule

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN engine: fetches sprite rows and XORs them into the framebuffer.
// Optional macro CHIP8_SPRITE_WRAP_EN wraps off-screen pixels instead of clipping.
module chip8_sprite_draw
    import chip8_pkg::*;
#(
    parameter int FB_W_BITS  = 6,
    parameter int FB_H_BITS  = 5,
    parameter int MEM_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            x_in,
    input  logic [7:0]            y_in,
    input  logic [3:0]            n_in,
    input  logic [MEM_ADDR_W-1:0] i_in,
    output logic                  busy,
    output logic                  done,
    output logic                  collision,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [7:0]            mem_readdata,
    output logic [FB_W_BITS-1:0]  fb_addr_x,
    output logic [FB_H_BITS-1:0]  fb_addr_y,
    output logic                  fb_writedata,
    output logic                  fb_WE,
    input  logic                  fb_readdata
);

    sprite_state_t         state_q, state_d;
    logic [FB_W_BITS-1:0]  x0_q, x0_d, fb_x_q, fb_x_d, px;
    logic [FB_H_BITS-1:0]  y0_q, y0_d, fb_y_q, fb_y_d, py;
    logic [3:0]            n_q, n_d, row_q, row_d, row_next;
    logic [MEM_ADDR_W-1:0] i_q, i_d, mem_addr_q, mem_addr_d;
    logic [2:0]            col_q, col_d, c_col;
    logic [7:0]            sprite_q, sprite_d, c_byte;
    logic                  collision_q, collision_d, fb_we_q, fb_we_d;
    logic                  c_bit, on_screen, more_rows, advance, enter_col;
    logic                  unused_hi;

    assign unused_hi = ^{x_in[7:FB_W_BITS], y_in[7:FB_H_BITS]};

    // Candidate column: col 0 right after LATCH, otherwise the next column.
    assign c_col     = (state_q == ST_LATCH) ? 3'd0 : col_q + 3'd1;
    assign c_byte    = (state_q == ST_LATCH) ? mem_readdata : sprite_q;
    assign c_bit     = c_byte[3'd7 - c_col];
    assign row_next  = row_q + 4'd1;
    assign more_rows = row_next < n_q;

    chip8_sprite_coord #(
        .FB_W_BITS(FB_W_BITS),
        .FB_H_BITS(FB_H_BITS)
    ) u_coord (
        .x0       (x0_q),
        .y0       (y0_q),
        .col      (c_col),
        .row      (row_q),
        .px       (px),
        .py       (py),
        .on_screen(on_screen)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            n_q         <= '0;
            i_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            sprite_q    <= '0;
            collision_q <= 1'b0;
            mem_addr_q  <= '0;
            fb_x_q      <= '0;
            fb_y_q      <= '0;
            fb_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            n_q         <= n_d;
            i_q         <= i_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sprite_q    <= sprite_d;
            collision_q <= collision_d;
            mem_addr_q  <= mem_addr_d;
            fb_x_q      <= fb_x_d;
            fb_y_q      <= fb_y_d;
            fb_we_q     <= fb_we_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        n_d         = n_q;
        i_d         = i_q;
        row_d       = row_q;
        col_d       = col_q;
        sprite_d    = sprite_q;
        collision_d = collision_q;
        mem_addr_d  = mem_addr_q;
        fb_x_d      = fb_x_q;
        fb_y_d      = fb_y_q;
        fb_we_d     = 1'b0;
        advance     = 1'b0;
        enter_col   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x0_d        = x_in[FB_W_BITS-1:0];
                    y0_d        = y_in[FB_H_BITS-1:0];
                    n_d         = n_in;
                    i_d         = i_in;
                    row_d       = '0;
                    collision_d = 1'b0;
                    if (n_in == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_FETCH;
                        mem_addr_d = i_in;
                    end
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                sprite_d  = mem_readdata;
                col_d     = 3'd0;
                enter_col = 1'b1;
            end
            ST_READ: begin
                state_d = ST_WRITE;
                fb_we_d = 1'b1;
            end
            ST_WRITE: begin
                advance     = 1'b1;
                collision_d = collision_q | fb_readdata;
            end
            ST_SKIP: advance = 1'b1;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            if (col_q != 3'd7) begin
                col_d     = c_col;
                enter_col = 1'b1;
            end else if (more_rows) begin
                row_d      = row_next;
                mem_addr_d = i_q + {{(MEM_ADDR_W-4){1'b0}}, row_next};
                state_d    = ST_FETCH;
            end else begin
                state_d = ST_DONE;
            end
        end
        if (enter_col) begin
            if (c_bit && on_screen) begin
                state_d = ST_READ;
                fb_x_d  = px;
                fb_y_d  = py;
            end else begin
                state_d = ST_SKIP;
            end
        end
    end

    always_comb begin
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        fb_writedata = (state_q == ST_WRITE) && !fb_readdata;
    end

    assign collision = collision_q;
    assign mem_addr  = mem_addr_q;
    assign fb_addr_x = fb_x_q;
    assign fb_addr_y = fb_y_q;
    assign fb_WE     = fb_we_q;

endmodule
